// File: rtl/seg_scan_if.sv
// Bundles the scan driver's CE pacing, digit data inputs and display drive outputs.
// The driver connects through the slave modport. The digit encoders and the prescaler use the master modport.
interface seg_scan_if #(
  parameter int DIGITS = 8
);
  logic                  CE;
  logic [7*DIGITS-1:0]   seg_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     digit_en;
  logic [3:0]            bright;
  logic [6:0]            seg_out;
  logic                  dp_out;
  logic [DIGITS-1:0]     seg_select;
  logic                  frame_tick;

  modport master (
    output CE, seg_in, dp_in, digit_en, bright,
    input  seg_out, dp_out, seg_select, frame_tick
  );

  modport slave (
    input  CE, seg_in, dp_in, digit_en, bright,
    output seg_out, dp_out, seg_select, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment scan driver. Each digit gets one slot of 2^DWELL_W CE cycles.
// A slot opens with a dead time, then brightness PWM gates the digit select. Each digit can be blanked.
module seg_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int DWELL_W        = 10,
  parameter int BLANK_CYC      = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input logic        CLK,
  input logic        CLR,
  seg_scan_if.slave  bus
);
  localparam int                 IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]   LAST    = IDX_W'(DIGITS - 1);
  localparam logic [DWELL_W-1:0] BLANK   = DWELL_W'(BLANK_CYC);
  localparam logic [6:0]         SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0]  SEL_OFF = {DIGITS{SEL_ACTIVE_LOW}};

  logic [DWELL_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0]   idx, idx_nx;
  logic               slot_end, frame_end, sel_on;
  logic [DIGITS-1:0]  sel_nx;
  logic [6:0]         seg_nx;
  logic               dp_nx;

  logic [6:0]         seg_q;
  logic               dp_q;
  logic [DIGITS-1:0]  sel_q;
  logic               tick_q;

  // Outputs are computed from the post-edge position, so the registered drive matches the new cnt/idx.
  always_comb begin
    slot_end  = &cnt;
    frame_end = slot_end && (idx == LAST);
    cnt_nx    = cnt + 1'b1;
    idx_nx    = idx;
    if (slot_end) idx_nx = frame_end ? '0 : idx + 1'b1;
    sel_on    = (cnt_nx >= BLANK) &&
                (cnt_nx[DWELL_W-1 -: 4] <= bus.bright) &&
                bus.digit_en[idx_nx];
    sel_nx         = '0;
    sel_nx[idx_nx] = sel_on;
    seg_nx    = bus.seg_in[7*idx_nx +: 7];
    dp_nx     = bus.dp_in[idx_nx];
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt    <= '0;
      idx    <= '0;
      seg_q  <= SEG_OFF;
      dp_q   <= SEG_ACTIVE_LOW;
      sel_q  <= SEL_OFF;
      tick_q <= 1'b0;
    end else begin
      tick_q <= bus.CE && frame_end;
      if (bus.CE) begin
        cnt   <= cnt_nx;
        idx   <= idx_nx;
        sel_q <= sel_nx ^ SEL_OFF;
        // Segment data is latched only at slot entry, so mid-slot input changes never tear a digit.
        if (cnt_nx == '0) begin
          seg_q <= seg_nx ^ SEG_OFF;
          dp_q  <= dp_nx ^ SEG_ACTIVE_LOW;
        end
      end
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_q;
  assign bus.seg_select = sel_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, DWELL_W=6, BLANK_CYC=2, active-low drive.
// k counts the CE edges since the last reset, so slot position = k%64 and digit = (k/64)%4.
module tb_seg_scan_driver;
  logic CLK = 1'b0;
  logic CLR;
  int   errors = 0;
  int   checks = 0;
  int   k = 0;
  int   on_cnt, hit_cnt;

  seg_scan_if #(.DIGITS(4)) bus ();

  seg_scan_driver #(
    .DIGITS(4), .DWELL_W(6), .BLANK_CYC(2),
    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK),
    .CLR(CLR),
    .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_sel(input int kk);
    int c, d;
    logic [3:0] r;
    c = kk % 64;
    d = (kk / 64) % 4;
    r = 4'hf;
    if (c >= 2 && (c / 4) <= int'(bus.bright) && bus.digit_en[d]) r[d] = 1'b0;
    return r;
  endfunction

  // One clock. The select and the tick are checked every cycle against the slot-position model.
  task automatic step();
    logic ce_now;
    ce_now = bus.CE;
    @(posedge CLK);
    #1;
    if (ce_now) k++;
    chk("sel", 32'(bus.seg_select), 32'(exp_sel(k)));
    chk("tick", 32'(bus.frame_tick), 32'(ce_now && k > 0 && (k % 256) == 0));
  endtask

  task automatic run_to(input int n);
    while (k < n) step();
  endtask

  initial begin
    CLR          = 1'b1;
    bus.CE       = 1'b1;
    bus.bright   = 4'd15;
    bus.digit_en = 4'hf;
    bus.seg_in   = {7'b1001111, 7'b0000110, 7'b1011011, 7'b0111111};
    bus.dp_in    = 4'b0001;

    @(posedge CLK);
    #1;
    chk("rst_sel", 32'(bus.seg_select), 32'h0f);
    chk("rst_seg", 32'(bus.seg_out), 32'h7f);
    chk("rst_dp", 32'(bus.dp_out), 32'h1);
    chk("rst_tick", 32'(bus.frame_tick), 32'h0);
    CLR = 1'b0;

    step();
    chk("blank_k1", 32'(bus.seg_select), 32'h0f);
    step();
    chk("first_sel", 32'(bus.seg_select), 32'h0e);
    chk("d0_not_loaded", 32'(bus.seg_out), 32'h7f);

    run_to(74);
    chk("d1_seg", 32'(bus.seg_out), 32'(7'b0100100));
    chk("d1_dp", 32'(bus.dp_out), 32'h1);

    run_to(148);
    chk("d2_seg_mid", 32'(bus.seg_out), 32'(7'b1111001));
    bus.seg_in[20:14] = 7'b1111101;
    run_to(191);
    chk("d2_seg_end", 32'(bus.seg_out), 32'(7'b1111001));

    run_to(266);
    chk("d0_seg", 32'(bus.seg_out), 32'(7'b1000000));
    chk("d0_dp", 32'(bus.dp_out), 32'h0);

    run_to(389);
    chk("d2_seg_new", 32'(bus.seg_out), 32'(7'b0000010));

    run_to(512);
    bus.bright = 4'd7;
    on_cnt = 0;
    while (k < 576) begin
      step();
      if (bus.seg_select != 4'hf) on_cnt++;
    end
    chk("on_bright7", 32'(on_cnt), 32'd30);

    bus.bright = 4'd0;
    on_cnt = 0;
    while (k < 640) begin
      step();
      if (bus.seg_select != 4'hf) on_cnt++;
    end
    chk("on_bright0", 32'(on_cnt), 32'd2);

    bus.bright   = 4'd15;
    bus.digit_en = 4'b1011;
    on_cnt  = 0;
    hit_cnt = 0;
    while (k < 896) begin
      step();
      if (bus.seg_select != 4'hf) on_cnt++;
      if (bus.seg_select == 4'b1011) hit_cnt++;
    end
    chk("blank_d2_hits", 32'(hit_cnt), 32'd0);
    chk("blank_on_total", 32'(on_cnt), 32'd186);
    bus.digit_en = 4'hf;

    run_to(1023);
    bus.CE = 1'b0;
    repeat (100) step();
    chk("freeze_k", 32'(k), 32'd1023);
    chk("freeze_sel", 32'(bus.seg_select), 32'h07);
    chk("freeze_seg", 32'(bus.seg_out), 32'(7'b0110000));
    bus.CE = 1'b1;
    step();
    chk("tick_after_freeze", 32'(bus.frame_tick), 32'h1);
    chk("sel_after_wrap", 32'(bus.seg_select), 32'h0f);

    run_to(1100);
    CLR = 1'b1;
    #1;
    chk("mid_rst_sel", 32'(bus.seg_select), 32'h0f);
    chk("mid_rst_seg", 32'(bus.seg_out), 32'h7f);
    chk("mid_rst_dp", 32'(bus.dp_out), 32'h1);
    chk("mid_rst_tick", 32'(bus.frame_tick), 32'h0);
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    k = 0;
    step();
    chk("mid_rst_k1", 32'(bus.seg_select), 32'h0f);
    step();
    chk("mid_rst_k2", 32'(bus.seg_select), 32'h0e);
    chk("mid_rst_seg_k2", 32'(bus.seg_out), 32'h7f);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised time-multiplexed driver for common-anode/cathode 7-segment banks in the chess clock display path. It scans DIGITS digit positions, giving each a fixed slot of 2^DWELL_W clock-enable cycles. Each slot adds a dead time against ghosting, 16-level brightness PWM and per-digit blanking for blinking the active player's time. Digit encoders feed it; a prescaled CE strobe paces it.

## Interface
Parameters:
- DIGITS, 8, number of digit positions scanned (1..16)
- DWELL_W, 10, slot length is 2^DWELL_W CE cycles; must be >= 5
- BLANK_CYC, 4, dead-time CE cycles at slot start; must be < 2^(DWELL_W-4)
- SEG_ACTIVE_LOW, 1, 1: segment/dp outputs low = lit
- SEL_ACTIVE_LOW, 1, 1: seg_select low = digit enabled

Ports:
- CLK  in  1  clock
- CLR  in  1  reset, asynchronous, active-high
- CE  in  1  clock enable; state advances only on CLK edges with CE=1
- seg_in  in  7*DIGITS  digit i pattern at bits [7i+6:7i]; logical 1 = segment lit
- dp_in  in  DIGITS  decimal point per digit, 1 = lit
- digit_en  in  DIGITS  1 = digit shown, 0 = digit dark (select stays inactive)
- bright  in  4  brightness, 0 = 1/16 duty, 15 = full
- seg_out  out  7  segment drive, polarity per SEG_ACTIVE_LOW
- dp_out  out  1  decimal point drive, same polarity
- seg_select  out  DIGITS  one-hot digit enable, polarity per SEL_ACTIVE_LOW
- frame_tick  out  1  one-CLK pulse at completion of each full scan

## Operation
- State: slot counter cnt (DWELL_W bits), digit index idx (0..DIGITS-1).
- Per CE edge: cnt <= cnt+1. At cnt = 2^DWELL_W-1: cnt wraps to 0 and idx <= idx+1, wrapping DIGITS-1 -> 0.
- All outputs are registered. Each is a function of the post-edge (cnt, idx).
- On entry to a slot (new cnt = 0): seg_out/dp_out load seg_in/dp_in of the new idx, inverted if SEG_ACTIVE_LOW. seg_in/dp_in changes mid-slot are not shown until that digit's next slot.
- Select bit idx is active iff cnt >= BLANK_CYC, cnt[DWELL_W-1:DWELL_W-4] <= bright, and digit_en[idx] = 1. All other select bits are always inactive.
- bright and digit_en are sampled every CE edge and take effect mid-slot.
- During dead time and PWM-off phase, segment drive holds its value and only the select is gated.
- frame_tick = 1 for one CLK after the CE edge where idx wraps DIGITS-1 -> 0. It is 0 on every other edge, including CE=0 edges.
- DIGITS=1: idx is constantly 0, seg_out reloads each slot, frame_tick fires every slot.
- CE=0: cnt, idx, seg_out, dp_out and seg_select hold.

## Timing
- CLR asserted, at any time including mid-slot: immediately cnt=0 and idx=0. All seg_select inactive. seg_out and dp_out show off (all 1 when SEG_ACTIVE_LOW). frame_tick=0.
- After CLR release, the first CE edge gives cnt=1 on digit 0. Digit 0 segment data loads only at the next slot entry of digit 0. Digits 1.. load at their slot entries.
- Slot = 2^DWELL_W CE cycles. Frame = DIGITS*2^DWELL_W CE cycles.
- On-time per slot = min(2^DWELL_W, (bright+1)*2^(DWELL_W-4)) - BLANK_CYC CE cycles.
- Two select bits are never active in the same cycle. At least BLANK_CYC CE cycles of all-inactive precede each digit change.

## Test plan
Common setup for all scenarios: DIGITS=4, DWELL_W=6, BLANK_CYC=2, both polarities active-low, CE=1 every cycle.
- Reset: pulse CLR mid-scan -> same cycle, seg_select=4'b1111, seg_out=7'b1111111, dp_out=1, frame_tick=0. First active select after release is 4'b1110 only after cnt reaches 2.
- Scan order and dead time, with bright=15 and all digit_en=1:
  - seg_select follows 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Each digit's select is low for 62 cycles, followed by 2 cycles of 1111 at every digit change.
  - frame_tick pulses once per 256 cycles, in the cycle after digit 3 -> 0.
- Data load: seg_in digit 2 = 7'b0000110 ("1"), then change it mid-slot -> seg_out = 7'b1111001 for the whole digit-2 slot; the new value appears only in the next frame.
- Brightness: bright=7 -> selects active for cnt 2..31 (30 cycles) per slot. bright=0 -> active for cnt 2..3 (2 cycles).
- Blanking and CE:
  - digit_en=4'b1011 -> seg_select never 1011; the slot timing of other digits is unchanged.
  - Holding CE=0 for 100 cycles freezes all outputs; frame_tick stays 0 throughout.
